// File: rtl/mem_arbiter_pkg.sv
// cpu_parameters: shared CPU-wide constants and the memory arbiter state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   xlen                - machine word width, default for all address/data buses
//   DEFAULT_MAX_STREAK  - data grants allowed back-to-back while a fetch waits
//   DEFAULT_TIMEOUT     - cycles a memory transaction may stay unacknowledged
//   arb_state_t         - arbiter FSM encoding
package cpu_parameters;

  localparam int xlen               = 32;
  localparam int DEFAULT_MAX_STREAK = 4;
  localparam int DEFAULT_TIMEOUT    = 64;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of fetch-port, data-port and downstream-memory signals.
// Latency: n/a (wiring only).
// Backpressure: req_v/req_rdy handshake per CPU port; memory side completes on mem_ack.
//
// Modports:
//   slave  - the arbiter's view (takes CPU requests and memory completions)
//   master - the environment's view (CPU ports plus the memory model)
interface mem_arbiter_if #(
  parameter int XLEN = cpu_parameters::xlen
);

  // instruction fetch port
  logic            i_req_v;
  logic [XLEN-1:0] i_req_adr;
  logic            i_req_rdy;
  logic            i_resp_v;
  logic [XLEN-1:0] i_resp;

  // data port
  logic            d_req_v;
  logic            d_req_we;
  logic [XLEN-1:0] d_req_adr;
  logic [XLEN-1:0] d_req_data;
  logic [3:0]      d_req_strobe;
  logic            d_req_rdy;
  logic            d_resp_v;
  logic [XLEN-1:0] d_resp;

  // downstream memory
  logic            mem_r_v;
  logic            mem_w_v;
  logic [XLEN-1:0] mem_adr;
  logic [XLEN-1:0] mem_data;
  logic [3:0]      mem_strobe;
  logic [XLEN-1:0] mem_resp;
  logic            mem_ack;

  // status
  logic            err;

  modport slave (
    input  i_req_v, i_req_adr,
    output i_req_rdy, i_resp_v, i_resp,
    input  d_req_v, d_req_we, d_req_adr, d_req_data, d_req_strobe,
    output d_req_rdy, d_resp_v, d_resp,
    output mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe,
    input  mem_resp, mem_ack,
    output err
  );

  modport master (
    output i_req_v, i_req_adr,
    input  i_req_rdy, i_resp_v, i_resp,
    output d_req_v, d_req_we, d_req_adr, d_req_data, d_req_strobe,
    input  d_req_rdy, d_resp_v, d_resp,
    input  mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe,
    output mem_resp, mem_ack,
    input  err
  );

endinterface

// File: rtl/mem_arbiter_timer.sv
// mem_arb_timer: counts cycles spent waiting on one memory transaction.
// Latency: o_expire rises in the TIMEOUT-th busy cycle (count TIMEOUT-1).
// Backpressure: none; restarts from zero whenever i_busy drops.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_busy    - high while the arbiter owns an outstanding transaction
//   o_expire  - high in the last busy cycle in which an ack is still acceptable
module mem_arb_timer
  import cpu_parameters::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_busy,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Counter is 0 in the first busy cycle, so LAST marks busy cycle number TIMEOUT.
  assign o_expire = i_busy && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !i_busy) begin
      r_cnt <= '0;
    end else if (!o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-outstanding memory port between fetch and data requests.
// Latency: accept in cycle N -> mem valid at N+1; mem_ack at M -> resp_v pulse at M+1 (min 2).
// Backpressure: req_rdy only while idle; data has priority, fetch wins after MAX_STREAK data grants.
//
// Ports:
//   clk, rst  - sole clock (rising edge), synchronous active-high reset
//   bus       - mem_arbiter_if.slave: fetch port, data port, downstream memory, sticky err
//
// Build option: define MEM_ARB_TIMEOUT_EN to abort transactions whose mem_ack does not
// arrive within TIMEOUT busy cycles; err is then set and the owner gets resp_v with 0.
module mem_arbiter
  import cpu_parameters::*;
#(
  parameter int XLEN       = xlen,
  parameter int MAX_STREAK = DEFAULT_MAX_STREAK,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  if (MAX_STREAK < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mem_arbiter: MAX_STREAK and TIMEOUT must both be at least 1");
  end

  arb_state_t          r_state;
  logic [STREAK_W-1:0] r_streak;

  // Latched request, driven straight onto the memory port while busy.
  logic [XLEN-1:0]     r_adr;
  logic [XLEN-1:0]     r_data;
  logic [3:0]          r_strobe;
  logic                r_mem_r_v;
  logic                r_mem_w_v;

  logic                r_i_resp_v;
  logic [XLEN-1:0]     r_i_resp;
  logic                r_d_resp_v;
  logic [XLEN-1:0]     r_d_resp;

  logic                w_idle;
  logic                w_busy;
  logic                w_i_first;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_timeout;
  logic                w_done;
  logic [XLEN-1:0]     w_resp_dat;
  logic [STREAK_W-1:0] w_streak_inc;

  assign w_idle = (r_state == ARB_IDLE);
  assign w_busy = !w_idle;

  // Fetch only overrides data once the streak has saturated with a fetch waiting.
  assign w_i_first = bus.i_req_v && (r_streak == STREAK_MAX);
  assign w_grant_d = w_idle && bus.d_req_v && !w_i_first;
  assign w_grant_i = w_idle && bus.i_req_v && !w_grant_d;

  assign bus.i_req_rdy = w_grant_i;
  assign bus.d_req_rdy = w_grant_d;

  assign w_streak_inc = (r_streak == STREAK_MAX) ? r_streak : r_streak + 1'b1;

`ifdef MEM_ARB_TIMEOUT_EN
  logic w_expire;
  logic r_err;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_busy   (w_busy),
    .o_expire (w_expire)
  );

  // A real ack in the expiry cycle still completes normally.
  assign w_timeout = w_expire && !bus.mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign w_done     = w_busy && (bus.mem_ack || w_timeout);
  assign w_resp_dat = bus.mem_ack ? bus.mem_resp : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_streak   <= '0;
      r_adr      <= '0;
      r_data     <= '0;
      r_strobe   <= '0;
      r_mem_r_v  <= 1'b0;
      r_mem_w_v  <= 1'b0;
      r_i_resp_v <= 1'b0;
      r_i_resp   <= '0;
      r_d_resp_v <= 1'b0;
      r_d_resp   <= '0;
    end else begin
      r_i_resp_v <= 1'b0;
      r_d_resp_v <= 1'b0;

      case (r_state)
        ARB_IDLE: begin
          if (w_grant_d) begin
            r_state   <= ARB_BUSY_D;
            r_adr     <= bus.d_req_adr;
            r_data    <= bus.d_req_data;
            r_strobe  <= bus.d_req_strobe;
            r_mem_r_v <= !bus.d_req_we;
            r_mem_w_v <= bus.d_req_we;
            // The streak only measures how long a waiting fetch has been starved.
            r_streak  <= bus.i_req_v ? w_streak_inc : '0;
          end else if (w_grant_i) begin
            r_state   <= ARB_BUSY_I;
            r_adr     <= bus.i_req_adr;
            r_data    <= '0;
            r_strobe  <= 4'hF;
            r_mem_r_v <= 1'b1;
            r_mem_w_v <= 1'b0;
            r_streak  <= '0;
          end
        end

        ARB_BUSY_I, ARB_BUSY_D: begin
          if (w_done) begin
            r_state   <= ARB_IDLE;
            r_mem_r_v <= 1'b0;
            r_mem_w_v <= 1'b0;
            if (r_state == ARB_BUSY_I) begin
              r_i_resp_v <= 1'b1;
              r_i_resp   <= w_resp_dat;
            end else begin
              r_d_resp_v <= 1'b1;
              r_d_resp   <= w_resp_dat;
            end
          end
        end

        default: begin
          r_state   <= ARB_IDLE;
          r_mem_r_v <= 1'b0;
          r_mem_w_v <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_r_v    = r_mem_r_v;
  assign bus.mem_w_v    = r_mem_w_v;
  assign bus.mem_adr    = r_adr;
  assign bus.mem_data   = r_data;
  assign bus.mem_strobe = r_strobe;

  assign bus.i_resp_v   = r_i_resp_v;
  assign bus.i_resp     = r_i_resp;
  assign bus.d_resp_v   = r_d_resp_v;
  assign bus.d_resp     = r_d_resp;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory model.
// Latency: memory model acks 0..3 cycles after it first sees a valid.
// Backpressure: drivers hold req_v until the matching req_rdy is sampled high.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int XLEN       = 32;
  localparam int MAX_STREAK = 4;
  localparam int TIMEOUT    = 64;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  strobe;
  } bus_t;

  logic clk;
  logic rst;

  mem_arbiter_if #(.XLEN(XLEN)) bus ();

  mem_arbiter #(
    .XLEN       (XLEN),
    .MAX_STREAK (MAX_STREAK),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bus_t        exp_bus[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  byte         grants[$];

  bit outstanding = 0;
  int d_run       = 0;
  int lat_mode    = -1;
  bit mem_stall   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents as the model sees them; 0x10 holds a NOP.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // ---------------- memory responder + bus checker ----------------
  bit          seen = 0;
  int          wait_left = 0;
  logic [31:0] first_adr, first_data;

  initial begin : responder
    bus_t e;
    bus.mem_ack  = 1'b0;
    bus.mem_resp = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (!rst && (bus.mem_r_v || bus.mem_w_v)) begin
        if (!seen) begin
          seen       = 1;
          wait_left  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
          first_adr  = bus.mem_adr;
          first_data = bus.mem_data;
          if (exp_bus.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL bus_unexpected: got valid adr 0x%08h required none", bus.mem_adr);
          end else begin
            e = exp_bus.pop_front();
            check("bus_r_v", 32'(bus.mem_r_v), 32'(!e.we));
            check("bus_w_v", 32'(bus.mem_w_v), 32'(e.we));
            check("bus_adr", bus.mem_adr, e.adr);
            check("bus_data", bus.mem_data, e.data);
            check("bus_strobe", 32'(bus.mem_strobe), 32'(e.strobe));
          end
        end else begin
          check("bus_stable_adr", bus.mem_adr, first_adr);
          check("bus_stable_data", bus.mem_data, first_data);
        end
        if (!mem_stall) begin
          if (wait_left == 0) begin
            bus.mem_ack  = 1'b1;
            bus.mem_resp = bus.mem_r_v ? mem_word(bus.mem_adr) : bus.mem_data;
          end else begin
            wait_left--;
          end
        end
      end else begin
        seen = 0;
        // Junk on the bus while idle must be ignored.
        bus.mem_ack  = ($urandom_range(0, 7) == 0);
        bus.mem_resp = $urandom;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.i_resp_v) begin
          if (exp_i.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL i_resp_unexpected: got 0x%08h required no pulse", bus.i_resp);
          end else check("i_resp", bus.i_resp, exp_i.pop_front());
        end
        if (bus.d_resp_v) begin
          if (exp_d.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL d_resp_unexpected: got 0x%08h required no pulse", bus.d_resp);
          end else check("d_resp", bus.d_resp, exp_d.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic new_i(input logic [31:0] adr);
    bus.i_req_v   = 1'b1;
    bus.i_req_adr = adr;
  endtask

  task automatic new_d(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] stb);
    bus.d_req_v      = 1'b1;
    bus.d_req_we     = we;
    bus.d_req_adr    = adr;
    bus.d_req_data   = dat;
    bus.d_req_strobe = stb;
  endtask

  // One clock: check ready against the arbitration rules, log accepts, drop accepted reqs.
  task automatic step();
    logic ia, da, exp_ir, exp_dr;
    @(negedge clk);
    if (bus.i_resp_v || bus.d_resp_v) outstanding = 0;
    ia = !rst && bus.i_req_v && bus.i_req_rdy;
    da = !rst && bus.d_req_v && bus.d_req_rdy;
    if (!rst) begin
      exp_dr = !outstanding && bus.d_req_v && !(bus.i_req_v && d_run >= MAX_STREAK);
      exp_ir = !outstanding && bus.i_req_v && !exp_dr;
      check("i_req_rdy", 32'(bus.i_req_rdy), 32'(exp_ir));
      check("d_req_rdy", 32'(bus.d_req_rdy), 32'(exp_dr));
    end
    if (ia) begin
      outstanding = 1;
      d_run = 0;
      grants.push_back(8'd73);
      exp_bus.push_back('{1'b0, bus.i_req_adr, 32'h0, 4'hF});
      exp_i.push_back(mem_word(bus.i_req_adr));
    end
    if (da) begin
      outstanding = 1;
      d_run = bus.i_req_v ? ((d_run < MAX_STREAK) ? d_run + 1 : MAX_STREAK) : 0;
      grants.push_back(8'd68);
      exp_bus.push_back('{bus.d_req_we, bus.d_req_adr, bus.d_req_data, bus.d_req_strobe});
      exp_d.push_back(bus.d_req_we ? bus.d_req_data : mem_word(bus.d_req_adr));
    end
    @(posedge clk);
    #1;
    if (ia) bus.i_req_v = 1'b0;
    if (da) bus.d_req_v = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.i_req_v = 1'b0;
    bus.d_req_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b0;
    outstanding = 0;
    d_run       = 0;
    exp_bus.delete();
    exp_i.delete();
    exp_d.delete();
    grants.delete();
  endtask

  task automatic drain();
    bus.i_req_v = 1'b0;
    bus.d_req_v = 1'b0;
    for (int k = 0; k < 60 && (exp_i.size() != 0 || exp_d.size() != 0); k++) step();
    step();
    check("drain_i_empty", 32'(exp_i.size()), 32'd0);
    check("drain_d_empty", 32'(exp_d.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    bus.i_req_v = 0; bus.i_req_adr = 0;
    bus.d_req_v = 0; bus.d_req_we = 0; bus.d_req_adr = 0;
    bus.d_req_data = 0; bus.d_req_strobe = 0;
    rst = 1'b1;

    // Reset state
    do_reset();
    check("rst_mem_r_v", 32'(bus.mem_r_v), 0);
    check("rst_mem_w_v", 32'(bus.mem_w_v), 0);
    check("rst_mem_adr", bus.mem_adr, 0);
    check("rst_mem_data", bus.mem_data, 0);
    check("rst_mem_strobe", 32'(bus.mem_strobe), 0);
    check("rst_i_resp_v", 32'(bus.i_resp_v), 0);
    check("rst_d_resp_v", 32'(bus.d_resp_v), 0);
    check("rst_i_resp", bus.i_resp, 0);
    check("rst_d_resp", bus.d_resp, 0);
    check("rst_err", 32'(bus.err), 0);

    // Single fetch, 1-cycle ack
    lat_mode = 0;
    new_i(32'h10);
    step();
    check("fetch_mem_r_v", 32'(bus.mem_r_v), 1);
    check("fetch_mem_adr", bus.mem_adr, 32'h10);
    check("fetch_mem_strobe", 32'(bus.mem_strobe), 32'hF);
    check("fetch_mem_data", bus.mem_data, 0);
    step();
    check("fetch_i_resp_v", 32'(bus.i_resp_v), 1);
    check("fetch_i_resp", bus.i_resp, 32'h13);
    drain();

    // Simultaneous requests: data write wins
    do_reset();
    lat_mode = 2;
    new_i(32'h100);
    new_d(1'b1, 32'h0002_0000, 32'hDEAD_BEEF, 4'h3);
    step();
    check("wr_mem_w_v", 32'(bus.mem_w_v), 1);
    check("wr_mem_r_v", 32'(bus.mem_r_v), 0);
    check("wr_mem_adr", bus.mem_adr, 32'h0002_0000);
    check("wr_mem_data", bus.mem_data, 32'hDEAD_BEEF);
    check("wr_mem_strobe", 32'(bus.mem_strobe), 32'h3);
    k = 0;
    while (k < 10 && !bus.d_resp_v) begin
      step();
      k++;
    end
    check("wr_d_resp_seen", 32'(bus.d_resp_v), 1);
    step();
    check("wr_then_fetch", 32'(bus.mem_r_v), 1);
    drain();

    // Both requesters saturated: DDDDI repeating
    do_reset();
    lat_mode = 0;
    for (int c = 0; c < 40; c++) begin
      if (!bus.i_req_v) new_i(32'($urandom) & 32'hFFFC);
      if (!bus.d_req_v) new_d(1'($urandom), 32'($urandom) & 32'hFFFC, $urandom, 4'($urandom));
      step();
    end
    check("streak_grant_count_ok", 32'(grants.size() >= 15), 1);
    for (int g = 0; g < 15 && g < grants.size(); g++)
      check("streak_pattern", 32'(grants[g]), (g % 5 == 4) ? 32'd73 : 32'd68);
    drain();

    // Reset while a data write waits on a stalled memory
    do_reset();
    lat_mode  = 0;
    mem_stall = 1;
    new_d(1'b1, 32'h0000_0040, 32'h1111_2222, 4'hF);
    repeat (3) step();
    check("abort_busy_w_v", 32'(bus.mem_w_v), 1);
    rst = 1'b1;
    step();
    check("abort_mem_w_v", 32'(bus.mem_w_v), 0);
    check("abort_d_resp_v", 32'(bus.d_resp_v), 0);
    rst = 1'b0;
    void'(exp_d.pop_back());
    outstanding = 0;
    d_run       = 0;
    mem_stall   = 0;
    repeat (5) step();
    new_d(1'b0, 32'h0000_0080, 32'h0, 4'hF);
    step();
    drain();

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: abort after TIMEOUT busy cycles
    do_reset();
    mem_stall = 1;
    new_d(1'b0, 32'h0000_0200, 32'h0, 4'hF);
    step();
    void'(exp_d.pop_back());
    exp_d.push_back(32'h0);
    k = 0;
    while (k < TIMEOUT + 20 && !bus.d_resp_v) begin
      step();
      k++;
    end
    check("tmo_latency", 32'(k), 32'(TIMEOUT));
    check("tmo_d_resp", bus.d_resp, 0);
    check("tmo_err", 32'(bus.err), 1);
    mem_stall = 0;
    new_i(32'h10);
    step();
    drain();
    check("tmo_err_sticky", 32'(bus.err), 1);
    do_reset();
    check("tmo_err_cleared", 32'(bus.err), 0);
`endif

    // Randomised traffic with random memory latency
    do_reset();
    lat_mode = -1;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.i_req_v && $urandom_range(0, 3) == 0) new_i(32'($urandom) & 32'hFFFC);
      if (!bus.d_req_v && $urandom_range(0, 2) == 0)
        new_d(1'($urandom), 32'($urandom) & 32'hFFFC, $urandom, 4'($urandom));
      step();
    end
    drain();
`ifndef MEM_ARB_TIMEOUT_EN
    check("err_tied_low", 32'(bus.err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
